// File: rtl/clock_divider.sv
// Square-wave clock divider: toggles clk_out every HALF enabled clk edges and
// emits a one-cycle tick in the clk domain on each rising edge of clk_out.
module clock_divider #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int OUT_FREQ_HZ = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic clk_out,
  output logic tick
);

  localparam int HALF = CLK_FREQ_HZ / (2 * OUT_FREQ_HZ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  if (HALF < 1) begin : g_bad_params
    $fatal(1, "clock_divider: OUT_FREQ_HZ*2 exceeds CLK_FREQ_HZ");
  end

  logic [CW-1:0] cnt;

  // tick mirrors the 0->1 toggle, so it is derived from the old clk_out value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (enable) begin
        if (cnt == LAST) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= ~clk_out;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: three instances (HALF=5, 1, 3) share reset/enable and
// are checked each cycle against a model based on the count of enabled edges.
module tb_clock_divider;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic co [3];
  logic tk [3];

  int compared = 0;
  int mismatched = 0;

  // HALF=5, HALF=1, and HALF=13/4=3 with the remainder dropped.
  int h [3] = '{5, 1, 3};

  clock_divider #(.CLK_FREQ_HZ(10), .OUT_FREQ_HZ(1)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .clk_out(co[0]), .tick(tk[0]));
  clock_divider #(.CLK_FREQ_HZ(2), .OUT_FREQ_HZ(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .clk_out(co[1]), .tick(tk[1]));
  clock_divider #(.CLK_FREQ_HZ(13), .OUT_FREQ_HZ(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .clk_out(co[2]), .tick(tk[2]));

  always #5 clk = ~clk;

  // Model: n = enabled edges since reset; everything follows from n and HALF.
  int n = 0;
  bit last_en = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n = 0;
      last_en = 1'b0;
    end else begin
      last_en = enable;
      if (enable) n = n + 1;
    end
  end

  function automatic int exp_cnt(int i);
    return n % h[i];
  endfunction

  function automatic int exp_out(int i);
    return (n / h[i]) % 2;
  endfunction

  function automatic int exp_tick(int i);
    return (last_en && (n % (2 * h[i]) == h[i])) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    compared = compared + 1;
    if (act != exp) begin
      mismatched = mismatched + 1;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int dut_cnt(int i);
    case (i)
      0: return int'(dut0.cnt);
      1: return int'(dut1.cnt);
      default: return int'(dut2.cnt);
    endcase
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_clk_out[%0d]", i), int'(co[i]), exp_out(i));
      chk($sformatf("model_tick[%0d]", i), int'(tk[i]), exp_tick(i));
      chk($sformatf("model_cnt[%0d]", i), dut_cnt(i), exp_cnt(i));
    end
  end

  task automatic edge_chk();
    @(posedge clk);
    #3;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("reset_async_clk_out", int'(co[0]), 0);
    chk("reset_async_tick", int'(tk[0]), 0);
    repeat (3) begin
      edge_chk();
      chk("reset_hold_clk_out", int'(co[0]), 0);
      chk("reset_hold_tick", int'(tk[0]), 0);
      chk("reset_hold_cnt", int'(dut0.cnt), 0);
    end
    @(negedge clk) reset = 1'b1;

    // Free run: rises on edge 5 and 15, falls on edge 10.
    for (int k = 1; k <= 16; k++) begin
      edge_chk();
      if (k == 1) begin
        chk("half1_first_rise", int'(co[1]), 1);
        chk("half1_first_tick", int'(tk[1]), 1);
      end
      if (k == 2) begin
        chk("half1_fall", int'(co[1]), 0);
        chk("half1_no_tick", int'(tk[1]), 0);
      end
      if (k == 3) chk("half3_rise_edge3", int'(co[2]), 1);
      if (k == 4) chk("free_before_rise", int'(co[0]), 0);
      if (k == 5) begin
        chk("free_rise_edge5", int'(co[0]), 1);
        chk("free_tick_edge5", int'(tk[0]), 1);
      end
      if (k == 6) chk("free_tick_one_cycle", int'(tk[0]), 0);
      if (k == 10) begin
        chk("free_fall_edge10", int'(co[0]), 0);
        chk("free_no_tick_on_fall", int'(tk[0]), 0);
      end
      if (k == 15) begin
        chk("free_rise_edge15", int'(co[0]), 1);
        chk("free_tick_edge15", int'(tk[0]), 1);
      end
    end

    // Advance to cnt=3, then pause for 7 cycles.
    repeat (2) edge_chk();
    chk("pause_start_cnt", int'(dut0.cnt), 3);
    @(negedge clk) enable = 1'b0;
    repeat (7) begin
      edge_chk();
      chk("pause_cnt_frozen", int'(dut0.cnt), 3);
      chk("pause_clk_out_frozen", int'(co[0]), 1);
      chk("pause_tick_low", int'(tk[0]), 0);
    end
    @(negedge clk) enable = 1'b1;
    edge_chk();
    chk("resume_edge1_no_toggle", int'(co[0]), 1);
    edge_chk();
    chk("resume_edge2_toggle", int'(co[0]), 0);

    // Reach cnt=4 with clk_out=1, then reset mid-cycle.
    repeat (9) edge_chk();
    chk("mid_reset_pre_cnt", int'(dut0.cnt), 4);
    chk("mid_reset_pre_out", int'(co[0]), 1);
    #1 reset = 1'b0;
    #1;
    chk("mid_reset_async_out", int'(co[0]), 0);
    chk("mid_reset_async_cnt", int'(dut0.cnt), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      edge_chk();
      if (k == 4) chk("post_reset_before_rise", int'(co[0]), 0);
      if (k == 5) chk("post_reset_rise_edge5", int'(co[0]), 1);
    end

    // enable drops exactly when the wrap is due: the wrap is held off.
    repeat (4) edge_chk();
    chk("wrap_hold_pre_cnt", int'(dut0.cnt), 4);
    @(negedge clk) enable = 1'b0;
    repeat (3) begin
      edge_chk();
      chk("wrap_hold_cnt", int'(dut0.cnt), 4);
      chk("wrap_hold_out", int'(co[0]), 1);
    end
    @(negedge clk) enable = 1'b1;
    edge_chk();
    chk("wrap_resume_toggle", int'(co[0]), 0);
    chk("wrap_resume_cnt", int'(dut0.cnt), 0);

    // Random enable and reset activity, checked by the per-cycle compare.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 3) != 0);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 59) == 0) reset = 1'b0;
      else if ($urandom_range(0, 79) == 0) begin
        @(posedge clk);
        #3 reset = 1'b0;
      end
    end
    @(negedge clk) reset = 1'b1;
    enable = 1'b1;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
